// File: rtl/motion_pkg.sv
// Shared types and constants for the motion frame scheduler.
//   state_t  : frame sequencer states
//   PIPE_LAT : cycles from a frame-buffer read strobe to its mask beat
//   pixel_t  : 8-bit pixel sample
package motion_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int PIPE_LAT = 2;

    typedef logic [7:0] pixel_t;

endpackage

// File: rtl/raster_addr_gen.sv
// Raster-order pixel address generator.
// Keeps x/y/linear-address counters, zeroed by clear and stepped by advance.
// last flags the final pixel of the frame; stepping past it wraps to pixel 0.
// Optional feature macro: MOTION_ROI_EN -- adds inclusive ROI bounds, latched on
// clear, and roi_hit reports whether the current x/y lies inside them.
// Without the macro roi_hit is tied high (whole frame is the ROI).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   clear           zero the counters (and latch ROI bounds)
//   advance         step to the next pixel in raster order
//   roi_x0..roi_y1  ROI bounds (MOTION_ROI_EN only)
//   addr            y*IMG_W + x
//   last            current pixel is x=IMG_W-1, y=IMG_H-1
//   roi_hit         current pixel lies inside the ROI
module raster_addr_gen #(
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240,
    parameter int ADDR_W = 17
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     advance,
`ifdef MOTION_ROI_EN
    input  logic [$clog2(IMG_W)-1:0] roi_x0,
    input  logic [$clog2(IMG_W)-1:0] roi_x1,
    input  logic [$clog2(IMG_H)-1:0] roi_y0,
    input  logic [$clog2(IMG_H)-1:0] roi_y1,
`endif
    output logic [ADDR_W-1:0]        addr,
    output logic                     last,
    output logic                     roi_hit
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    assign last = (x_q == X_LAST) && (y_q == Y_LAST);
    assign addr = addr_q;

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        addr_d = addr_q;
        if (clear || (advance && last)) begin
            x_d    = '0;
            y_d    = '0;
            addr_d = '0;
        end else if (advance) begin
            addr_d = addr_q + 1'b1;
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q    <= '0;
            y_q    <= '0;
            addr_q <= '0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            addr_q <= addr_d;
        end
    end

`ifdef MOTION_ROI_EN
    logic [XW-1:0] rx0_q, rx0_d, rx1_q, rx1_d;
    logic [YW-1:0] ry0_q, ry0_d, ry1_q, ry1_d;

    always_comb begin
        rx0_d = rx0_q;
        rx1_d = rx1_q;
        ry0_d = ry0_q;
        ry1_d = ry1_q;
        if (clear) begin
            rx0_d = roi_x0;
            rx1_d = roi_x1;
            ry0_d = roi_y0;
            ry1_d = roi_y1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx0_q <= '0;
            rx1_q <= '0;
            ry0_q <= '0;
            ry1_q <= '0;
        end else begin
            rx0_q <= rx0_d;
            rx1_q <= rx1_d;
            ry0_q <= ry0_d;
            ry1_q <= ry1_d;
        end
    end

    // Inverted bounds can never satisfy both compares, so they give an empty ROI.
    assign roi_hit = (x_q >= rx0_q) && (x_q <= rx1_q) &&
                     (y_q >= ry0_q) && (y_q <= ry1_q);
`else
    assign roi_hit = 1'b1;
`endif

endmodule

// File: rtl/motion_frame_scheduler.sv
// Frame-level sequencer for the per-pixel motion detector.
// On start it raster-scans one IMG_W x IMG_H frame, strobes frame-buffer reads,
// forwards the returned pixels to the detector and turns the detector results
// into a mask stream, a saturating motion count and a per-frame verdict.
// Optional feature macro: MOTION_ROI_EN -- adds roi_x0/x1/y0/y1 inputs; pixels
// outside the ROI still get a mask beat but with mask_bit forced low.
//
//   state | meaning
//   IDLE  | waiting for start
//   SCAN  | one read issued per cycle in raster order
//   DRAIN | PIPE_LAT cycles letting the last reads reach the mask stream
//   DONE  | one-cycle completion, verdict captured
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   start, abort                   frame request / cancel
//   threshold_in, min_count        detector threshold (latched), verdict limit
//   rd_en, rd_addr                 frame-buffer read request
//   rd_curr, rd_prev, rd_sigma     read data, one cycle after rd_en
//   det_enable .. det_threshold    detector drive
//   det_motion                     detector result, one cycle after det_enable
//   mask_valid, mask_addr, mask_bit  per-pixel result stream
//   busy, done                     status
//   motion_count, frame_motion     frame statistics
module motion_frame_scheduler
    import motion_pkg::*;
#(
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240,
    parameter int ADDR_W = 17,
    parameter int CNT_W  = 17
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic [7:0]               threshold_in,
    input  logic [CNT_W-1:0]         min_count,
`ifdef MOTION_ROI_EN
    input  logic [$clog2(IMG_W)-1:0] roi_x0,
    input  logic [$clog2(IMG_W)-1:0] roi_x1,
    input  logic [$clog2(IMG_H)-1:0] roi_y0,
    input  logic [$clog2(IMG_H)-1:0] roi_y1,
`endif
    output logic                     rd_en,
    output logic [ADDR_W-1:0]        rd_addr,
    input  logic [7:0]               rd_curr,
    input  logic [7:0]               rd_prev,
    input  logic                     rd_sigma,
    output logic                     det_enable,
    output logic [7:0]               det_curr,
    output logic [7:0]               det_prev,
    output logic                     det_sigma,
    output logic [7:0]               det_threshold,
    input  logic                     det_motion,
    output logic                     mask_valid,
    output logic [ADDR_W-1:0]        mask_addr,
    output logic                     mask_bit,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_W-1:0]         motion_count,
    output logic                     frame_motion
);

    state_t            state_q, state_d;
    logic [1:0]        drain_q, drain_d;
    pixel_t            thr_q, thr_d;
    logic              det_en_q, det_en_d;
    logic              mval_q, mval_d;
    logic [ADDR_W-1:0] addr1_q, addr1_d, addr2_q, addr2_d;
    logic              hit1_q, hit1_d, hit2_q, hit2_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              fm_q, fm_d;

    logic              gen_clear, gen_advance, gen_last, gen_hit;
    logic [ADDR_W-1:0] gen_addr;
    logic              accept, kill, verdict;

    raster_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_raster_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .clear   (gen_clear),
        .advance (gen_advance),
`ifdef MOTION_ROI_EN
        .roi_x0  (roi_x0),
        .roi_x1  (roi_x1),
        .roi_y0  (roi_y0),
        .roi_y1  (roi_y1),
`endif
        .addr    (gen_addr),
        .last    (gen_last),
        .roi_hit (gen_hit)
    );

    // abort beats start in IDLE; abort only cancels an active scan.
    assign accept  = (state_q == IDLE) && start && !abort;
    assign kill    = abort && ((state_q == SCAN) || (state_q == DRAIN));
    assign verdict = (cnt_q >= min_count);

    assign rd_en         = (state_q == SCAN);
    assign rd_addr       = rd_en ? gen_addr : '0;
    assign det_enable    = det_en_q;
    assign det_curr      = det_en_q ? rd_curr : 8'd0;
    assign det_prev      = det_en_q ? rd_prev : 8'd0;
    assign det_sigma     = det_en_q & rd_sigma;
    assign det_threshold = thr_q;
    assign mask_valid    = mval_q;
    assign mask_addr     = mval_q ? addr2_q : '0;
    assign mask_bit      = mval_q & hit2_q & det_motion;
    assign busy          = (state_q == SCAN) || (state_q == DRAIN);
    assign done          = (state_q == DONE);
    assign motion_count  = cnt_q;
    // Verdict is visible during the done pulse, then held by fm_q.
    assign frame_motion  = done ? verdict : fm_q;

    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        thr_d       = thr_q;
        cnt_d       = cnt_q;
        fm_d        = fm_q;
        gen_clear   = 1'b0;
        gen_advance = 1'b0;
        det_en_d    = rd_en;
        addr1_d     = rd_addr;
        hit1_d      = gen_hit;
        mval_d      = det_en_q;
        addr2_d     = addr1_q;
        hit2_d      = hit1_q;

        if (mask_bit && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = SCAN;
                    thr_d     = threshold_in;
                    cnt_d     = '0;
                    gen_clear = 1'b1;
                end
            end
            SCAN: begin
                gen_advance = 1'b1;
                if (gen_last) begin
                    state_d = DRAIN;
                    drain_d = 2'(PIPE_LAT - 1);
                end
            end
            DRAIN: begin
                if (drain_q == 2'd0)
                    state_d = DONE;
                else
                    drain_d = drain_q - 1'b1;
            end
            DONE: begin
                state_d = IDLE;
                fm_d    = verdict;
            end
            default: state_d = IDLE;
        endcase

        // Cancel flushes the result pipeline so no stale beat escapes.
        if (kill) begin
            state_d  = IDLE;
            det_en_d = 1'b0;
            mval_d   = 1'b0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            drain_q  <= '0;
            thr_q    <= '0;
            det_en_q <= 1'b0;
            mval_q   <= 1'b0;
            addr1_q  <= '0;
            addr2_q  <= '0;
            hit1_q   <= 1'b0;
            hit2_q   <= 1'b0;
            cnt_q    <= '0;
            fm_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            thr_q    <= thr_d;
            det_en_q <= det_en_d;
            mval_q   <= mval_d;
            addr1_q  <= addr1_d;
            addr2_q  <= addr2_d;
            hit1_q   <= hit1_d;
            hit2_q   <= hit2_d;
            cnt_q    <= cnt_d;
            fm_q     <= fm_d;
        end
    end

endmodule

// File: tb/tb_motion_frame_scheduler.sv
module tb_motion_frame_scheduler;

    localparam int W = 4;
    localparam int H = 2;
    localparam int N = W * H;
    localparam int AW = 3;
    localparam int CW = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [7:0]    threshold_in = 8'd0;
    logic [CW-1:0] min_count = '0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_curr = 8'd0;
    logic [7:0]    rd_prev = 8'd0;
    logic          rd_sigma = 1'b0;
    logic          det_enable;
    logic [7:0]    det_curr, det_prev, det_threshold;
    logic          det_sigma;
    logic          det_motion = 1'b0;
    logic          mask_valid, mask_bit, busy, done, frame_motion;
    logic [AW-1:0] mask_addr;
    logic [CW-1:0] motion_count;
`ifdef MOTION_ROI_EN
    logic [1:0]    roi_x0 = 2'd0, roi_x1 = 2'd3;
    logic          roi_y0 = 1'b0, roi_y1 = 1'b1;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] m_curr [N];
    logic [7:0] m_prev [N];
    logic       m_sig  [N];

    motion_frame_scheduler #(
        .IMG_W(W), .IMG_H(H), .ADDR_W(AW), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .threshold_in(threshold_in), .min_count(min_count),
`ifdef MOTION_ROI_EN
        .roi_x0(roi_x0), .roi_x1(roi_x1), .roi_y0(roi_y0), .roi_y1(roi_y1),
`endif
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_curr(rd_curr), .rd_prev(rd_prev),
        .rd_sigma(rd_sigma), .det_enable(det_enable), .det_curr(det_curr),
        .det_prev(det_prev), .det_sigma(det_sigma), .det_threshold(det_threshold),
        .det_motion(det_motion), .mask_valid(mask_valid), .mask_addr(mask_addr),
        .mask_bit(mask_bit), .busy(busy), .done(done),
        .motion_count(motion_count), .frame_motion(frame_motion)
    );

    always #5 clk = ~clk;

    function automatic int absd(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    // Frame buffer: data returns the cycle after the read strobe.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_curr  <= m_curr[rd_addr];
            rd_prev  <= m_prev[rd_addr];
            rd_sigma <= m_sig[rd_addr];
        end
    end

    // Detector: registered result one cycle after det_enable.
    always @(posedge clk)
        det_motion <= det_enable && det_sigma &&
                      (absd(int'(det_curr), int'(det_prev)) > int'(det_threshold));

    function automatic bit in_roi(input int i);
`ifdef MOTION_ROI_EN
        int x = i % W;
        int y = i / W;
        return (x >= int'(roi_x0)) && (x <= int'(roi_x1)) &&
               (y >= int'(roi_y0)) && (y <= int'(roi_y1));
`else
        return 1'b1;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill(input int c, input int p, input bit s);
        for (int i = 0; i < N; i++) begin
            m_curr[i] = 8'(c);
            m_prev[i] = 8'(p);
            m_sig[i]  = s;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_en"}, rd_en, 0);
        check({tag, "_rd_addr"}, rd_addr, 0);
        check({tag, "_det_en"}, det_enable, 0);
        check({tag, "_det_curr"}, det_curr, 0);
        check({tag, "_det_thr"}, det_threshold, 0);
        check({tag, "_mask_valid"}, mask_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_count"}, motion_count, 0);
        check({tag, "_fm"}, frame_motion, 0);
    endtask

    // Run one full frame and compare against the reference computed from memory.
    task automatic run_frame(input string tag, input logic [7:0] thr,
                             input logic [CW-1:0] minc, input bit poke_start);
        bit exp_bit [N];
        int exp_cnt = 0;
        int cyc = 0;
        int beats = 0;
        int done_at = -1;
        bit exp_fm;
        for (int i = 0; i < N; i++) begin
            exp_bit[i] = m_sig[i] && (absd(int'(m_curr[i]), int'(m_prev[i])) > int'(thr)) && in_roi(i);
            if (exp_bit[i]) exp_cnt++;
        end
        if (exp_cnt > CMAX) exp_cnt = CMAX;
        exp_fm = (exp_cnt >= int'(minc));

        @(negedge clk);
        start = 1'b1;
        threshold_in = thr;
        min_count = minc;
        while (done_at < 0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            start = poke_start && (cyc == 5);
            check({tag, "_rd_en"}, rd_en, (cyc <= N) ? 1 : 0);
            if (cyc <= N) check({tag, "_rd_addr"}, rd_addr, cyc - 1);
            if (mask_valid) begin
                if (beats < N) begin
                    check({tag, "_mask_addr"}, mask_addr, beats);
                    check({tag, "_mask_bit"}, mask_bit, exp_bit[beats]);
                end
                beats++;
            end
            if (done) done_at = cyc;
        end
        start = 1'b0;
        check({tag, "_done_latency"}, done_at, N + 3);
        check({tag, "_beats"}, beats, N);
        check({tag, "_thr"}, det_threshold, thr);
        check({tag, "_count"}, motion_count, exp_cnt);
        check({tag, "_fm"}, frame_motion, exp_fm);
        check({tag, "_busy_at_done"}, busy, 0);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_fm_hold"}, frame_motion, exp_fm);
    endtask

    task automatic idle_no_done(input string tag, input int ncyc);
        int seen = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        check({tag, "_no_done"}, seen, 0);
        check({tag, "_idle_busy"}, busy, 0);
    endtask

    initial begin
        bit fm_prev;
        fill(0, 0, 1'b0);

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_all_zero("reset");

        // 1: |50-40| == thr, no motion; min_count 0 still yields a positive verdict
        fill(50, 40, 1'b1);
        run_frame("t1", 8'd10, 3'd0, 1'b0);

        // 2: motion at 3 and 6
        fill(0, 0, 1'b1);
        m_curr[3] = 8'd100;
        m_curr[6] = 8'd100;
        run_frame("t2", 8'd10, 3'd2, 1'b0);

        // 3: same but sigma off at 6
        m_sig[6] = 1'b0;
        run_frame("t3", 8'd10, 3'd2, 1'b0);

        // 4: abort in the 4th SCAN cycle
        fill(200, 0, 1'b1);
        fm_prev = frame_motion;
        @(negedge clk);
        start = 1'b1;
        threshold_in = 8'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t4_rd_en", rd_en, 0);
        check("t4_det_en", det_enable, 0);
        check("t4_mask_valid", mask_valid, 0);
        check("t4_busy", busy, 0);
        check("t4_count", motion_count, 0);
        check("t4_fm_kept", frame_motion, fm_prev);
        idle_no_done("t4", 15);
        check("t4_count_after", motion_count, 0);
        run_frame("t4_rerun", 8'd5, 3'd7, 1'b0);

        // start and abort together in IDLE: nothing happens
        fm_prev = frame_motion;
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("t4b_busy", busy, 0);
        check("t4b_rd_en", rd_en, 0);
        idle_no_done("t4b", 5);
        check("t4b_fm_kept", frame_motion, fm_prev);

        // 5: extra start while busy, then rst mid-SCAN
        fill(0, 0, 1'b1);
        m_curr[1] = 8'd90;
        run_frame("t5_poke", 8'd20, 3'd1, 1'b1);
        @(negedge clk);
        start = 1'b1;
        threshold_in = 8'd33;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("t5_rst");
        idle_no_done("t5_rst", 15);
        run_frame("t5_after", 8'd20, 3'd1, 1'b0);

        // Saturation: every pixel moves, count clamps at all-ones
        fill(255, 0, 1'b1);
        run_frame("sat", 8'd0, 3'(CMAX), 1'b0);

`ifdef MOTION_ROI_EN
        // 6: ROI x 1..2, y 1..1
        roi_x0 = 2'd1; roi_x1 = 2'd2; roi_y0 = 1'b1; roi_y1 = 1'b1;
        run_frame("t6_roi", 8'd0, 3'd2, 1'b0);
        // inverted bounds: empty ROI
        roi_x0 = 2'd3; roi_x1 = 2'd1; roi_y0 = 1'b0; roi_y1 = 1'b1;
        run_frame("t6_empty", 8'd0, 3'd1, 1'b0);
        roi_x0 = 2'd0; roi_x1 = 2'd3; roi_y0 = 1'b0; roi_y1 = 1'b1;
`endif

        // Randomized frames
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < N; i++) begin
                m_curr[i] = 8'($urandom_range(0, 255));
                m_prev[i] = 8'($urandom_range(0, 255));
                m_sig[i]  = 1'($urandom_range(0, 1));
            end
`ifdef MOTION_ROI_EN
            roi_x0 = 2'($urandom_range(0, 3));
            roi_x1 = 2'($urandom_range(0, 3));
            roi_y0 = 1'($urandom_range(0, 1));
            roi_y1 = 1'($urandom_range(0, 1));
`endif
            run_frame("rand", 8'($urandom_range(0, 120)), 3'($urandom_range(0, CMAX)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
